// File: rtl/npcg_toggle_pkg.sv
// Shared constants and types for the NPCG Toggle NAND sequencers.
package npcg_toggle_pkg;

  // Dispatcher command decode
  localparam logic [5:0] OPCODE_PROGRAM_DT = 6'b000001;
  localparam logic [4:0] TARGET_ID_BNC     = 5'b00101;

  // Bit positions of the primitive manager one-hot command vector
  localparam int PM_PBR   = 6;
  localparam int PM_CAL   = 3;
  localparam int PM_DO    = 2;
  localparam int PM_DI    = 1;
  localparam int PM_TIMER = 0;

  // NAND command bytes issued on the CAL primitive
  localparam logic [7:0] CMD_PROGRAM       = 8'h80;
  localparam logic [7:0] CMD_CHANGE_WCOL   = 8'h85;
  localparam logic [7:0] CMD_CHANGE_RCOL   = 8'h05;
  localparam logic [7:0] CMD_CHANGE_RCOL2  = 8'hE0;
  localparam logic [7:0] CMD_READ_MODE     = 8'h06;
  localparam logic [7:0] CMD_PROGRAM_CONF  = 8'h10;

  // Primitive lengths (PM encoding: value is count minus one)
  localparam logic [15:0] CAL_LEN_CMD_ADDR = 16'd5;
  localparam logic [15:0] TIMER_LEN_TADL   = 16'd29;
  localparam logic [15:0] TIMER_LEN_TAIL   = 16'd3;

  // Timer primitive options
  localparam logic [2:0] OPT_TIMER_TADL = 3'b001;
  localparam logic [2:0] OPT_TIMER_TAIL = 3'b100;
  localparam logic [2:0] OPT_DO_WORD    = 3'b001;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_PBR_ISSUE    = 4'd1,
    S_CMD_ISSUE    = 4'd2,
    S_CMD_WRITE0   = 4'd3,
    S_COL0         = 4'd4,
    S_COL1         = 4'd5,
    S_ROW0         = 4'd6,
    S_ROW1         = 4'd7,
    S_ROW2         = 4'd8,
    S_TIMER1_ISSUE = 4'd9,
    S_DO_ISSUE     = 4'd10,
    S_TIMER2_ISSUE = 4'd11,
    S_WAIT_DONE    = 4'd12
  } dt_state_t;

  // Build the one-hot PM trigger for a given primitive bit position
  function automatic logic [7:0] pm_onehot(input int idx);
    pm_onehot = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/npcg_toggle_bnc_p_program_dt80h_if.sv
// Command, upstream write stream and primitive manager signals of the
// program data-transfer sequencer. The sequencer uses the slave modport.
interface npcg_toggle_bnc_p_program_dt80h_if #(
  parameter int NumberOfWays = 4
);
  logic [5:0]              iOpcode;
  logic [4:0]              iTargetID;
  logic [4:0]              iSourceID;
  logic [15:0]             iLength;
  logic                    iCMDValid;
  logic                    oCMDReady;
  logic [NumberOfWays-1:0] iWaySelect;
  logic [15:0]             iColAddress;
  logic [23:0]             iRowAddress;
  logic [31:0]             iWriteData;
  logic                    iWriteLast;
  logic                    iWriteValid;
  logic                    oWriteReady;
  logic                    oStart;
  logic                    oLastStep;
  logic                    oLengthMismatch;
  logic [7:0]              iPM_Ready;
  logic [7:0]              iPM_LastStep;
  logic [7:0]              oPM_PCommand;
  logic [2:0]              oPM_PCommandOption;
  logic [NumberOfWays-1:0] oPM_TargetWay;
  logic [15:0]             oPM_NumOfData;
  logic                    oPM_CASelect;
  logic [7:0]              oPM_CAData;
  logic [31:0]             oPM_WriteData;
  logic                    oPM_WriteLast;
  logic                    oPM_WriteValid;
  logic                    iPM_WriteReady;

  modport slave (
    input  iOpcode, iTargetID, iSourceID, iLength, iCMDValid, iWaySelect,
           iColAddress, iRowAddress, iWriteData, iWriteLast, iWriteValid,
           iPM_Ready, iPM_LastStep, iPM_WriteReady,
    output oCMDReady, oWriteReady, oStart, oLastStep, oLengthMismatch,
           oPM_PCommand, oPM_PCommandOption, oPM_TargetWay, oPM_NumOfData,
           oPM_CASelect, oPM_CAData, oPM_WriteData, oPM_WriteLast, oPM_WriteValid
  );

  modport master (
    output iOpcode, iTargetID, iSourceID, iLength, iCMDValid, iWaySelect,
           iColAddress, iRowAddress, iWriteData, iWriteLast, iWriteValid,
           iPM_Ready, iPM_LastStep, iPM_WriteReady,
    input  oCMDReady, oWriteReady, oStart, oLastStep, oLengthMismatch,
           oPM_PCommand, oPM_PCommandOption, oPM_TargetWay, oPM_NumOfData,
           oPM_CASelect, oPM_CAData, oPM_WriteData, oPM_WriteLast, oPM_WriteValid
  );
endinterface

// File: rtl/npcg_toggle_bnc_p_program_dt80h.sv
// Program-side data-transfer sequencer for one Toggle NAND way: waits for
// the bus, issues 80h/85h with column and row cycles, waits tADL, streams
// the write burst through DO, then runs the tail timer.
module npcg_toggle_bnc_p_program_dt80h
  import npcg_toggle_pkg::*;
#(
  parameter int NumberOfWays = 4
) (
  input logic iSystemClock,
  input logic iReset,
  npcg_toggle_bnc_p_program_dt80h_if.slave bus
);

  dt_state_t               state, next_state;
  logic [NumberOfWays-1:0] trf_way;
  logic [15:0]             trf_length;
  logic [15:0]             trf_col;
  logic [23:0]             trf_row;
  logic                    trf_change_col;
  logic [15:0]             beat_count;
  logic [15:0]             count_next;
  logic                    length_mismatch;
  logic                    trigger;
  logic                    data_phase;
  logic                    beat_accept;
  logic                    enter_done;
  logic [7:0]              pm_pcommand;
  logic [2:0]              pm_option;
  logic [15:0]             pm_num_of_data;
  logic                    pm_ca_select;
  logic [7:0]              pm_ca_data;

  assign trigger     = bus.iCMDValid && (bus.iTargetID == TARGET_ID_BNC) &&
                       (bus.iOpcode == OPCODE_PROGRAM_DT);
  assign data_phase  = (state == S_DO_ISSUE) || (state == S_TIMER2_ISSUE);
  assign beat_accept = data_phase && bus.iWriteValid && bus.iPM_WriteReady;
  assign count_next  = beat_count + {15'd0, beat_accept};
  assign enter_done  = (state == S_TIMER2_ISSUE) && bus.iPM_LastStep[PM_DO];

  // State register
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Command latch, beat counter and sticky length check
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      trf_way         <= '0;
      trf_length      <= '0;
      trf_col         <= '0;
      trf_row         <= '0;
      trf_change_col  <= 1'b0;
      beat_count      <= '0;
      length_mismatch <= 1'b0;
    end else if (state == S_IDLE && trigger) begin
      trf_way         <= bus.iWaySelect;
      trf_length      <= bus.iLength;
      trf_col         <= bus.iColAddress;
      trf_row         <= bus.iRowAddress;
      trf_change_col  <= bus.iSourceID[0];
      beat_count      <= '0;
      length_mismatch <= 1'b0;
    end else begin
      beat_count <= count_next;
      if (enter_done && (count_next != trf_length + 16'd1))
        length_mismatch <= 1'b1;
    end
  end

  // Next-state and primitive manager outputs decoded from state
  always_comb begin
    next_state     = state;
    pm_pcommand    = '0;
    pm_option      = '0;
    pm_num_of_data = '0;
    pm_ca_select   = 1'b0;
    pm_ca_data     = '0;
    case (state)
      S_IDLE: if (trigger) next_state = S_PBR_ISSUE;
      S_PBR_ISSUE: begin
        pm_pcommand = pm_onehot(PM_PBR);
        if (bus.iPM_Ready[6:0] == 7'h7F) next_state = S_CMD_ISSUE;
      end
      S_CMD_ISSUE: begin
        pm_pcommand    = pm_onehot(PM_CAL);
        pm_num_of_data = CAL_LEN_CMD_ADDR;
        if (bus.iPM_LastStep[PM_PBR]) next_state = S_CMD_WRITE0;
      end
      S_CMD_WRITE0: begin
        pm_ca_data = trf_change_col ? CMD_CHANGE_WCOL : CMD_PROGRAM;
        next_state = S_COL0;
      end
      S_COL0: begin
        pm_ca_select = 1'b1;
        pm_ca_data   = trf_col[7:0];
        next_state   = S_COL1;
      end
      S_COL1: begin
        pm_ca_select = 1'b1;
        pm_ca_data   = trf_col[15:8];
        next_state   = S_ROW0;
      end
      S_ROW0: begin
        pm_ca_select = 1'b1;
        pm_ca_data   = trf_row[7:0];
        next_state   = S_ROW1;
      end
      S_ROW1: begin
        pm_ca_select = 1'b1;
        pm_ca_data   = trf_row[15:8];
        next_state   = S_ROW2;
      end
      S_ROW2: begin
        pm_ca_select = 1'b1;
        pm_ca_data   = trf_row[23:16];
        next_state   = S_TIMER1_ISSUE;
      end
      S_TIMER1_ISSUE: begin
        pm_pcommand    = pm_onehot(PM_TIMER);
        pm_option      = OPT_TIMER_TADL;
        pm_num_of_data = TIMER_LEN_TADL;
        if (bus.iPM_LastStep[PM_CAL]) next_state = S_DO_ISSUE;
      end
      S_DO_ISSUE: begin
        pm_pcommand    = pm_onehot(PM_DO);
        pm_option      = OPT_DO_WORD;
        pm_num_of_data = trf_length;
        if (bus.iPM_LastStep[PM_TIMER]) next_state = S_TIMER2_ISSUE;
      end
      S_TIMER2_ISSUE: begin
        pm_pcommand    = pm_onehot(PM_TIMER);
        pm_option      = OPT_TIMER_TAIL;
        pm_num_of_data = TIMER_LEN_TAIL;
        if (bus.iPM_LastStep[PM_DO]) next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (bus.iPM_LastStep[PM_TIMER]) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.oCMDReady          = (state == S_IDLE);
  assign bus.oStart             = trigger;
  assign bus.oLastStep          = (state == S_WAIT_DONE) && bus.iPM_LastStep[PM_TIMER];
  assign bus.oLengthMismatch    = length_mismatch;
  assign bus.oPM_PCommand       = pm_pcommand;
  assign bus.oPM_PCommandOption = pm_option;
  assign bus.oPM_NumOfData      = pm_num_of_data;
  assign bus.oPM_CASelect       = pm_ca_select;
  assign bus.oPM_CAData         = pm_ca_data;
  assign bus.oPM_TargetWay      = trf_way;
  assign bus.oPM_WriteData      = bus.iWriteData;
  assign bus.oPM_WriteLast      = bus.iWriteLast;
  assign bus.oPM_WriteValid     = bus.iWriteValid && data_phase;
  assign bus.oWriteReady        = bus.iPM_WriteReady && data_phase;

endmodule

// File: tb/tb_npcg_toggle_bnc_p_program_dt80h.sv
// Directed bench for the program data-transfer sequencer. The PM side is
// driven by hand; inputs change and outputs are sampled on the falling edge.
module tb_npcg_toggle_bnc_p_program_dt80h;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  npcg_toggle_bnc_p_program_dt80h_if #(.NumberOfWays(4)) bus ();

  npcg_toggle_bnc_p_program_dt80h #(.NumberOfWays(4)) dut (
    .iSystemClock(clk),
    .iReset      (rst),
    .bus         (bus)
  );

  task automatic init_inputs();
    bus.iOpcode        = 6'd0;
    bus.iTargetID      = 5'd0;
    bus.iSourceID      = 5'd0;
    bus.iLength        = 16'd0;
    bus.iCMDValid      = 1'b0;
    bus.iWaySelect     = 4'd0;
    bus.iColAddress    = 16'd0;
    bus.iRowAddress    = 24'd0;
    bus.iWriteData     = 32'd0;
    bus.iWriteLast     = 1'b0;
    bus.iWriteValid    = 1'b0;
    bus.iPM_Ready      = 8'hFF;
    bus.iPM_LastStep   = 8'h00;
    bus.iPM_WriteReady = 1'b0;
  endtask

  task automatic set_cmd(input logic [4:0] src, input logic [3:0] way,
                         input logic [15:0] col, input logic [23:0] row,
                         input logic [15:0] len);
    bus.iOpcode     = 6'b000001;
    bus.iTargetID   = 5'b00101;
    bus.iSourceID   = src;
    bus.iWaySelect  = way;
    bus.iColAddress = col;
    bus.iRowAddress = row;
    bus.iLength     = len;
    bus.iCMDValid   = 1'b1;
  endtask

  // Trigger from Idle and walk the PM handshakes until the DO primitive is up
  task automatic drive_to_do(input logic [4:0] src, input logic [3:0] way,
                             input logic [15:0] len);
    @(negedge clk); set_cmd(src, way, 16'h1234, 24'hABCDEF, len);
    @(negedge clk); bus.iCMDValid = 1'b0; bus.iPM_Ready = 8'hFF;
    @(negedge clk); bus.iPM_LastStep = 8'h40;
    @(negedge clk); bus.iPM_LastStep = 8'h00;
    repeat (5) @(negedge clk);
    @(negedge clk); bus.iPM_LastStep = 8'h08;
    @(negedge clk); bus.iPM_LastStep = 8'h00;
  endtask

  // From DOIssue, complete DO, tail timer and WaitDone back to Idle
  task automatic finish_op();
    bus.iWriteValid = 1'b0;
    @(negedge clk); bus.iPM_LastStep = 8'h01;
    @(negedge clk); bus.iPM_LastStep = 8'h04;
    @(negedge clk); bus.iPM_LastStep = 8'h01;
    @(negedge clk); bus.iPM_LastStep = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    bus.iWriteValid    = 1'b1;
    bus.iPM_WriteReady = 1'b1;
    bus.iPM_LastStep   = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.oCMDReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got=%b exp=1", bus.oCMDReady); end
    checks++; if (bus.oPM_PCommand !== 8'h00) begin errors++; $display("[TB] FAIL reset_pcommand got=%h exp=00", bus.oPM_PCommand); end
    checks++; if (bus.oPM_PCommandOption !== 3'd0) begin errors++; $display("[TB] FAIL reset_option got=%b exp=000", bus.oPM_PCommandOption); end
    checks++; if (bus.oPM_NumOfData !== 16'd0) begin errors++; $display("[TB] FAIL reset_numofdata got=%h exp=0000", bus.oPM_NumOfData); end
    checks++; if (bus.oPM_CASelect !== 1'b0 || bus.oPM_CAData !== 8'h00) begin errors++; $display("[TB] FAIL reset_cal got=%b/%h exp=0/00", bus.oPM_CASelect, bus.oPM_CAData); end
    checks++; if (bus.oPM_TargetWay !== 4'd0) begin errors++; $display("[TB] FAIL reset_way got=%b exp=0000", bus.oPM_TargetWay); end
    checks++; if (bus.oWriteReady !== 1'b0 || bus.oPM_WriteValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_gate got=%b/%b exp=0/0", bus.oWriteReady, bus.oPM_WriteValid); end
    checks++; if (bus.oLastStep !== 1'b0 || bus.oLengthMismatch !== 1'b0) begin errors++; $display("[TB] FAIL reset_laststep_mismatch got=%b/%b exp=0/0", bus.oLastStep, bus.oLengthMismatch); end
    init_inputs();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_cal_sequence(input logic [4:0] src, input logic [7:0] first_byte);
    logic [7:0] exp_bytes [5];
    exp_bytes = '{8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB};
    @(negedge clk); set_cmd(src, 4'b0010, 16'h1234, 24'hABCDEF, 16'd3); #1;
    checks++; if (bus.oStart !== 1'b1) begin errors++; $display("[TB] FAIL cal_start got=%b exp=1", bus.oStart); end
    @(negedge clk); bus.iCMDValid = 1'b0; #1;
    checks++; if (bus.oPM_PCommand !== 8'h40) begin errors++; $display("[TB] FAIL cal_pbr_cmd got=%h exp=40", bus.oPM_PCommand); end
    @(negedge clk); bus.iPM_LastStep = 8'h40; #1;
    checks++; if (bus.oPM_PCommand !== 8'h08 || bus.oPM_NumOfData !== 16'd5) begin errors++; $display("[TB] FAIL cal_issue got=%h/%0d exp=08/5", bus.oPM_PCommand, bus.oPM_NumOfData); end
    checks++; if (bus.oPM_TargetWay !== 4'b0010) begin errors++; $display("[TB] FAIL cal_way got=%b exp=0010", bus.oPM_TargetWay); end
    @(negedge clk); bus.iPM_LastStep = 8'h00; #1;
    checks++; if (bus.oPM_CASelect !== 1'b0 || bus.oPM_CAData !== first_byte) begin errors++; $display("[TB] FAIL cal_cmd_byte got=%b/%h exp=0/%h", bus.oPM_CASelect, bus.oPM_CAData, first_byte); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.oPM_CASelect !== 1'b1 || bus.oPM_CAData !== exp_bytes[i]) begin errors++; $display("[TB] FAIL cal_addr_byte%0d got=%b/%h exp=1/%h", i, bus.oPM_CASelect, bus.oPM_CAData, exp_bytes[i]); end
    end
    @(negedge clk); bus.iPM_LastStep = 8'h08; #1;
    checks++; if (bus.oPM_PCommand !== 8'h01 || bus.oPM_PCommandOption !== 3'b001 || bus.oPM_NumOfData !== 16'd29) begin errors++; $display("[TB] FAIL cal_tadl got=%h/%b/%0d exp=01/001/29", bus.oPM_PCommand, bus.oPM_PCommandOption, bus.oPM_NumOfData); end
    @(negedge clk); bus.iPM_LastStep = 8'h00; #1;
    checks++; if (bus.oPM_PCommand !== 8'h04 || bus.oPM_PCommandOption !== 3'b001 || bus.oPM_NumOfData !== 16'd3) begin errors++; $display("[TB] FAIL cal_do_issue got=%h/%b/%0d exp=04/001/3", bus.oPM_PCommand, bus.oPM_PCommandOption, bus.oPM_NumOfData); end
    finish_op();
  endtask

  task automatic test_data_transfer();
    logic [31:0] words [4];
    int          k;
    int          cyc;
    logic        rdy;
    words = '{32'hDEAD0001, 32'hBEEF0002, 32'hCAFE0003, 32'h12340004};
    drive_to_do(5'd0, 4'b0001, 16'd3);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      rdy = cyc[0];
      bus.iWriteValid    = 1'b1;
      bus.iWriteData     = words[k];
      bus.iWriteLast     = (k == 3);
      bus.iPM_WriteReady = rdy;
      #1;
      checks++; if (bus.oPM_WriteValid !== 1'b1 || bus.oWriteReady !== rdy) begin errors++; $display("[TB] FAIL dt_handshake cyc%0d got=%b/%b exp=1/%b", cyc, bus.oPM_WriteValid, bus.oWriteReady, rdy); end
      checks++; if (bus.oPM_WriteData !== words[k] || bus.oPM_WriteLast !== (k == 3)) begin errors++; $display("[TB] FAIL dt_data beat%0d got=%h/%b exp=%h/%b", k, bus.oPM_WriteData, bus.oPM_WriteLast, words[k], (k == 3)); end
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    checks++; if (k != 4) begin errors++; $display("[TB] FAIL dt_beat_budget got=%0d exp=4", k); end
    bus.iWriteValid = 1'b0; bus.iWriteLast = 1'b0; bus.iPM_WriteReady = 1'b1; bus.iPM_LastStep = 8'h01; #1;
    checks++; if (bus.oPM_WriteValid !== 1'b0 || bus.oPM_PCommand !== 8'h04) begin errors++; $display("[TB] FAIL dt_idle_valid got=%b/%h exp=0/04", bus.oPM_WriteValid, bus.oPM_PCommand); end
    @(negedge clk); bus.iPM_LastStep = 8'h04; #1;
    checks++; if (bus.oPM_PCommand !== 8'h01 || bus.oPM_PCommandOption !== 3'b100 || bus.oPM_NumOfData !== 16'd3) begin errors++; $display("[TB] FAIL dt_tail_timer got=%h/%b/%0d exp=01/100/3", bus.oPM_PCommand, bus.oPM_PCommandOption, bus.oPM_NumOfData); end
    @(negedge clk); bus.iPM_LastStep = 8'h00; #1;
    checks++; if (bus.oLengthMismatch !== 1'b0 || bus.oLastStep !== 1'b0 || bus.oWriteReady !== 1'b0) begin errors++; $display("[TB] FAIL dt_wait_done got=%b/%b/%b exp=0/0/0", bus.oLengthMismatch, bus.oLastStep, bus.oWriteReady); end
    @(negedge clk); bus.iPM_LastStep = 8'h01; #1;
    checks++; if (bus.oLastStep !== 1'b1 || bus.oCMDReady !== 1'b0) begin errors++; $display("[TB] FAIL dt_last_step got=%b/%b exp=1/0", bus.oLastStep, bus.oCMDReady); end
    @(negedge clk); bus.iPM_LastStep = 8'h00; bus.iPM_WriteReady = 1'b0; #1;
    checks++; if (bus.oCMDReady !== 1'b1 || bus.oLastStep !== 1'b0 || bus.oLengthMismatch !== 1'b0) begin errors++; $display("[TB] FAIL dt_back_idle got=%b/%b/%b exp=1/0/0", bus.oCMDReady, bus.oLastStep, bus.oLengthMismatch); end
  endtask

  task automatic test_length_mismatch();
    drive_to_do(5'd0, 4'b1000, 16'd3);
    bus.iPM_WriteReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.iWriteValid = 1'b1;
      bus.iWriteData  = 32'h5000 + i;
      @(negedge clk);
    end
    bus.iWriteValid = 1'b0;
    bus.iPM_LastStep = 8'h01;
    @(negedge clk); bus.iPM_LastStep = 8'h04;
    @(negedge clk); bus.iPM_LastStep = 8'h00; #1;
    checks++; if (bus.oLengthMismatch !== 1'b1) begin errors++; $display("[TB] FAIL mm_set got=%b exp=1", bus.oLengthMismatch); end
    @(negedge clk); bus.iPM_LastStep = 8'h01;
    @(negedge clk); bus.iPM_LastStep = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.oLengthMismatch !== 1'b1 || bus.oCMDReady !== 1'b1) begin errors++; $display("[TB] FAIL mm_held got=%b/%b exp=1/1", bus.oLengthMismatch, bus.oCMDReady); end
    @(negedge clk); set_cmd(5'd0, 4'b0001, 16'h0, 24'h0, 16'd0);
    @(negedge clk); bus.iCMDValid = 1'b0; #1;
    checks++; if (bus.oLengthMismatch !== 1'b0) begin errors++; $display("[TB] FAIL mm_cleared got=%b exp=0", bus.oLengthMismatch); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; init_inputs();
  endtask

  task automatic test_pbr_stall();
    @(negedge clk); bus.iPM_Ready = 8'h3F; set_cmd(5'd0, 4'b0100, 16'h0, 24'h0, 16'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) set_cmd(5'd1, 4'b1000, 16'h0, 24'h0, 16'd1);
      else bus.iCMDValid = 1'b0;
      #1;
      checks++; if (bus.oPM_PCommand !== 8'h40) begin errors++; $display("[TB] FAIL stall_pbr cyc%0d got=%h exp=40", i, bus.oPM_PCommand); end
      if (i == 3) begin
        checks++; if (bus.oCMDReady !== 1'b0) begin errors++; $display("[TB] FAIL busy_cmd_ready got=%b exp=0", bus.oCMDReady); end
      end
    end
    bus.iCMDValid = 1'b0;
    bus.iPM_Ready = 8'hFF;
    @(negedge clk); #1;
    checks++; if (bus.oPM_PCommand !== 8'h08) begin errors++; $display("[TB] FAIL stall_release got=%h exp=08", bus.oPM_PCommand); end
    checks++; if (bus.oPM_TargetWay !== 4'b0100) begin errors++; $display("[TB] FAIL busy_trigger_ignored got=%b exp=0100", bus.oPM_TargetWay); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; init_inputs();
  endtask

  task automatic test_reset_mid_op();
    drive_to_do(5'd0, 4'b0010, 16'd3);
    bus.iWriteValid = 1'b1; bus.iPM_WriteReady = 1'b1; #1;
    checks++; if (bus.oWriteReady !== 1'b1 || bus.oPM_PCommand !== 8'h04) begin errors++; $display("[TB] FAIL rst_pre got=%b/%h exp=1/04", bus.oWriteReady, bus.oPM_PCommand); end
    rst = 1'b1; #1;
    checks++; if (bus.oPM_PCommand !== 8'h00 || bus.oWriteReady !== 1'b0 || bus.oCMDReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid got=%h/%b/%b exp=00/0/1", bus.oPM_PCommand, bus.oWriteReady, bus.oCMDReady); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (bus.oPM_PCommand !== 8'h00 || bus.oCMDReady !== 1'b1 || bus.oPM_WriteValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_after got=%h/%b/%b exp=00/1/0", bus.oPM_PCommand, bus.oCMDReady, bus.oPM_WriteValid); end
    init_inputs();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_cal_sequence(5'd0, 8'h80);
    test_cal_sequence(5'd1, 8'h85);
    test_data_transfer();
    test_length_mismatch();
    test_pbr_stall();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
